// File: rtl/mfp_ahb_spi_pkg.sv
// Shared definitions for the mfp AHB-Lite SPI TX FIFO peripheral:
// bus encodings, register offsets, register bit positions and FSM states.
package mfp_ahb_spi_pkg;

   // AHB-Lite HTRANS idle encoding, matching the mfp_ahb_const.vh value
   localparam logic [1:0] HTRANS_IDLE = 2'b00;

   // Register word offsets selected by HADDR[3:2]
   localparam logic [1:0] REG_TXDATA = 2'd0;
   localparam logic [1:0] REG_STATUS = 2'd1;
   localparam logic [1:0] REG_CTRL   = 2'd2;
   localparam logic [1:0] REG_RSVD   = 2'd3;

   // STATUS bit positions
   localparam int STATUS_BUSY_BIT  = 0;
   localparam int STATUS_FULL_BIT  = 1;
   localparam int STATUS_EMPTY_BIT = 2;
   localparam int STATUS_OVF_BIT   = 3;
   localparam int STATUS_COUNT_LSB = 8;

   // CTRL bit positions
   localparam int CTRL_EN_BIT     = 0;
   localparam int CTRL_IRQ_EN_BIT = 1;
   localparam int CTRL_DIV_LSB    = 8;

   // Serialiser states
   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      LOAD  = 2'd1,
      SHIFT = 2'd2,
      GAP   = 2'd3
   } spi_state_t;

endpackage

// File: rtl/mfp_ahb_spi_txfifo.sv
// Synchronous TX FIFO for the SPI peripheral. A push while full is dropped
// and reported on overflow; fullness is judged before any same-cycle pop.
module mfp_ahb_spi_txfifo #(
   parameter int DATA_W     = 16,
   parameter int FIFO_DEPTH = 8
) (
   input  logic                          HCLK,
   input  logic                          HRESETn,
   input  logic                          push,
   input  logic [DATA_W-1:0]             wdata,
   input  logic                          pop,
   output logic [DATA_W-1:0]             rdata,
   output logic                          full,
   output logic                          empty,
   output logic                          overflow,
   output logic [$clog2(FIFO_DEPTH):0]   count
);

   localparam int PTR_W = $clog2(FIFO_DEPTH);
   localparam int CNT_W = PTR_W + 1;

   logic [DATA_W-1:0] mem_q [FIFO_DEPTH];
   logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
   logic [CNT_W-1:0]  count_q, count_d;
   logic              push_ok;
   logic              pop_ok;

   assign full     = (count_q == CNT_W'(FIFO_DEPTH));
   assign empty    = (count_q == '0);
   assign push_ok  = push & ~full;
   assign pop_ok   = pop & ~empty;
   assign overflow = push & full;
   assign rdata    = mem_q[rd_ptr_q];
   assign count    = count_q;

   // Next pointers and occupancy; a push and pop together leave count alone
   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (push_ok) begin
         wr_ptr_d = wr_ptr_q + PTR_W'(1);
      end
      if (pop_ok) begin
         rd_ptr_d = rd_ptr_q + PTR_W'(1);
      end
      case ({push_ok, pop_ok})
         2'b10:   count_d = count_q + CNT_W'(1);
         2'b01:   count_d = count_q - CNT_W'(1);
         default: count_d = count_q;
      endcase
   end

   // Pointer and count registers, flushed by reset
   always_ff @(posedge HCLK or negedge HRESETn) begin
      if (!HRESETn) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   // Storage array; contents are don't-care until written
   always_ff @(posedge HCLK) begin
      if (push_ok) begin
         mem_q[wr_ptr_q] <= wdata;
      end
   end

endmodule

// File: rtl/mfp_ahb_spi_fifo.sv
// AHB-Lite SPI transmitter with TX FIFO, programmable SCLK divider and
// status/overflow reporting. Each queued word is sent MSB-first in SPI
// mode 0 on SCLK/MOSI/CS_N. The TX-done interrupt exists only when the
// SPI_TX_IRQ_EN macro is defined; otherwise IRQ is tied low and
// CTRL.IRQ_EN reads as zero.
module mfp_ahb_spi_fifo
   import mfp_ahb_spi_pkg::*;
#(
   parameter int DATA_W     = 16,
   parameter int FIFO_DEPTH = 8,
   parameter int DIV_W      = 8,
   parameter int DIV_RESET  = 49
) (
   input  logic        HCLK,
   input  logic        HRESETn,
   input  logic        HSEL,
   input  logic [1:0]  HTRANS,
   input  logic        HWRITE,
   input  logic [3:0]  HADDR,
   input  logic [31:0] HWDATA,
   output logic [31:0] HRDATA,
   output logic        SCLK,
   output logic        MOSI,
   output logic        CS_N,
   output logic        IRQ
);

   localparam int CNT_W  = $clog2(FIFO_DEPTH) + 1;
   localparam int BCNT_W = $clog2(DATA_W + 1);

   logic              dvalid_q, dvalid_d;
   logic              dwrite_q, dwrite_d;
   logic [1:0]        daddr_q, daddr_d;
   logic              en_q, en_d;
   logic [DIV_W-1:0]  div_q, div_d;
   logic              ovf_q, ovf_d;

   spi_state_t        state_q, state_d;
   logic              sclk_q, sclk_d;
   logic              mosi_q, mosi_d;
   logic              cs_n_q, cs_n_d;
   logic [DATA_W-1:0] shreg_q, shreg_d;
   logic [DIV_W-1:0]  hcnt_q, hcnt_d;
   logic [DIV_W-1:0]  fdiv_q, fdiv_d;
   logic [BCNT_W-1:0] bcnt_q, bcnt_d;

   logic              wr_commit;
   logic              txdata_wr;
   logic              status_wr;
   logic              ctrl_wr;
   logic              start;
   logic              do_load;
   logic              gap_exit;
   logic              busy;
   logic              irq_en;
   logic              fifo_pop;
   logic              fifo_full;
   logic              fifo_empty;
   logic              fifo_overflow;
   logic [DATA_W-1:0] fifo_rdata;
   logic [CNT_W-1:0]  fifo_count;
   logic              unused_inputs;

   assign unused_inputs = &{1'b0, HADDR[1:0], HWDATA};

   assign wr_commit = dvalid_q & dwrite_q;
   assign txdata_wr = wr_commit & (daddr_q == REG_TXDATA);
   assign status_wr = wr_commit & (daddr_q == REG_STATUS);
   assign ctrl_wr   = wr_commit & (daddr_q == REG_CTRL);
   assign start     = en_q & ~fifo_empty;
   assign busy      = (state_q != IDLE);

   assign SCLK = sclk_q;
   assign MOSI = mosi_q;
   assign CS_N = cs_n_q;

   mfp_ahb_spi_txfifo #(
      .DATA_W     (DATA_W),
      .FIFO_DEPTH (FIFO_DEPTH)
   ) u_txfifo (
      .HCLK     (HCLK),
      .HRESETn  (HRESETn),
      .push     (txdata_wr),
      .wdata    (HWDATA[DATA_W-1:0]),
      .pop      (fifo_pop),
      .rdata    (fifo_rdata),
      .full     (fifo_full),
      .empty    (fifo_empty),
      .overflow (fifo_overflow),
      .count    (fifo_count)
   );

   // Capture the address phase and update CTRL/OVF when the data phase commits
   always_comb begin
      dvalid_d = HSEL & (HTRANS != HTRANS_IDLE);
      dwrite_d = HWRITE;
      daddr_d  = HADDR[3:2];
      en_d     = en_q;
      div_d    = div_q;
      ovf_d    = ovf_q;
      if (ctrl_wr) begin
         en_d  = HWDATA[CTRL_EN_BIT];
         div_d = HWDATA[CTRL_DIV_LSB +: DIV_W];
      end
      if (status_wr && HWDATA[STATUS_OVF_BIT]) begin
         ovf_d = 1'b0;
      end
      if (fifo_overflow) begin
         ovf_d = 1'b1;
      end
   end

   // Bus pipeline and control registers
   always_ff @(posedge HCLK or negedge HRESETn) begin
      if (!HRESETn) begin
         dvalid_q <= 1'b0;
         dwrite_q <= 1'b0;
         daddr_q  <= 2'd0;
         en_q     <= 1'b1;
         div_q    <= DIV_W'(DIV_RESET);
         ovf_q    <= 1'b0;
      end else begin
         dvalid_q <= dvalid_d;
         dwrite_q <= dwrite_d;
         daddr_q  <= daddr_d;
         en_q     <= en_d;
         div_q    <= div_d;
         ovf_q    <= ovf_d;
      end
   end

   // Serialiser next state; a GAP that finds more work goes straight to LOAD
   always_comb begin
      state_d  = state_q;
      sclk_d   = sclk_q;
      mosi_d   = mosi_q;
      cs_n_d   = cs_n_q;
      shreg_d  = shreg_q;
      hcnt_d   = hcnt_q;
      fdiv_d   = fdiv_q;
      bcnt_d   = bcnt_q;
      fifo_pop = 1'b0;
      gap_exit = 1'b0;
      do_load  = 1'b0;
      case (state_q)
         IDLE: begin
            do_load = start;
         end
         LOAD: begin
            state_d = SHIFT;
         end
         SHIFT: begin
            if (hcnt_q == '0) begin
               hcnt_d = fdiv_q;
               sclk_d = ~sclk_q;
               if (!sclk_q) begin
                  bcnt_d = bcnt_q + BCNT_W'(1);
               end else if (bcnt_q == BCNT_W'(DATA_W)) begin
                  state_d = GAP;
                  sclk_d  = 1'b0;
                  cs_n_d  = 1'b1;
                  mosi_d  = 1'b0;
               end else begin
                  shreg_d = {shreg_q[DATA_W-2:0], 1'b0};
                  mosi_d  = shreg_q[DATA_W-2];
               end
            end else begin
               hcnt_d = hcnt_q - DIV_W'(1);
            end
         end
         GAP: begin
            if (hcnt_q == '0) begin
               if (start) begin
                  do_load = 1'b1;
               end else begin
                  state_d  = IDLE;
                  gap_exit = 1'b1;
               end
            end else begin
               hcnt_d = hcnt_q - DIV_W'(1);
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
      if (do_load) begin
         state_d  = LOAD;
         fifo_pop = 1'b1;
         shreg_d  = fifo_rdata;
         mosi_d   = fifo_rdata[DATA_W-1];
         cs_n_d   = 1'b0;
         sclk_d   = 1'b0;
         hcnt_d   = div_q;
         fdiv_d   = div_q;
         bcnt_d   = '0;
      end
   end

   // Serialiser state and registered SPI outputs
   always_ff @(posedge HCLK or negedge HRESETn) begin
      if (!HRESETn) begin
         state_q <= IDLE;
         sclk_q  <= 1'b0;
         mosi_q  <= 1'b0;
         cs_n_q  <= 1'b1;
         shreg_q <= '0;
         hcnt_q  <= '0;
         fdiv_q  <= '0;
         bcnt_q  <= '0;
      end else begin
         state_q <= state_d;
         sclk_q  <= sclk_d;
         mosi_q  <= mosi_d;
         cs_n_q  <= cs_n_d;
         shreg_q <= shreg_d;
         hcnt_q  <= hcnt_d;
         fdiv_q  <= fdiv_d;
         bcnt_q  <= bcnt_d;
      end
   end

`ifdef SPI_TX_IRQ_EN
   logic irq_en_q, irq_en_d;
   logic gap_exit_q;
   logic irq_q, irq_d;

   assign irq_en = irq_en_q;
   assign IRQ    = irq_q;

   // Raise IRQ the cycle after the FIFO drains; a TXDATA write or IRQ_EN=0 drops it
   always_comb begin
      irq_en_d = irq_en_q;
      irq_d    = irq_q;
      if (ctrl_wr) begin
         irq_en_d = HWDATA[CTRL_IRQ_EN_BIT];
      end
      if (gap_exit_q && fifo_empty && irq_en_q) begin
         irq_d = 1'b1;
      end
      if (txdata_wr || !irq_en_q) begin
         irq_d = 1'b0;
      end
   end

   // Interrupt enable, end-of-frame marker and interrupt flag
   always_ff @(posedge HCLK or negedge HRESETn) begin
      if (!HRESETn) begin
         irq_en_q   <= 1'b0;
         gap_exit_q <= 1'b0;
         irq_q      <= 1'b0;
      end else begin
         irq_en_q   <= irq_en_d;
         gap_exit_q <= gap_exit;
         irq_q      <= irq_d;
      end
   end
`else
   logic unused_irq;

   assign unused_irq = gap_exit;
   assign irq_en     = 1'b0;
   assign IRQ        = 1'b0;
`endif

   // Read mux driven from the registered address; no wait states
   always_comb begin
      HRDATA = '0;
      case (daddr_q)
         REG_STATUS: begin
            HRDATA[STATUS_BUSY_BIT]         = busy;
            HRDATA[STATUS_FULL_BIT]         = fifo_full;
            HRDATA[STATUS_EMPTY_BIT]        = fifo_empty;
            HRDATA[STATUS_OVF_BIT]          = ovf_q;
            HRDATA[STATUS_COUNT_LSB +: 8]   = 8'(fifo_count);
         end
         REG_CTRL: begin
            HRDATA[CTRL_EN_BIT]             = en_q;
            HRDATA[CTRL_IRQ_EN_BIT]         = irq_en;
            HRDATA[CTRL_DIV_LSB +: DIV_W]   = div_q;
         end
         default: begin
            HRDATA = '0;
         end
      endcase
   end

endmodule

// File: tb/tb_mfp_ahb_spi_fifo.sv
// Testbench for mfp_ahb_spi_fifo: register-access vector table followed by
// hand-written frame, back-to-back, divider, reset and interrupt sequences.
module tb_mfp_ahb_spi_fifo;

   localparam logic [3:0] ADDR_TX   = 4'h0;
   localparam logic [3:0] ADDR_ST   = 4'h4;
   localparam logic [3:0] ADDR_CTRL = 4'h8;
   localparam logic [3:0] ADDR_RSVD = 4'hC;

`ifdef SPI_TX_IRQ_EN
   localparam logic [31:0] CTRL_IRQ_READ = 32'h0000_0002;
`else
   localparam logic [31:0] CTRL_IRQ_READ = 32'h0000_0000;
`endif

   typedef struct {
      logic        isWrite;
      logic [3:0]  addr;
      logic [31:0] data;
      logic [31:0] expected;
      string       name;
   } vec_t;

   logic        HCLK;
   logic        HRESETn;
   logic        HSEL;
   logic [1:0]  HTRANS;
   logic        HWRITE;
   logic [3:0]  HADDR;
   logic [31:0] HWDATA;
   logic [31:0] HRDATA;
   logic        SCLK;
   logic        MOSI;
   logic        CS_N;
   logic        IRQ;

   int numVectors = 0;
   int numMiscompares = 0;
   vec_t vecs[$];

   mfp_ahb_spi_fifo dut (
      .HCLK    (HCLK),
      .HRESETn (HRESETn),
      .HSEL    (HSEL),
      .HTRANS  (HTRANS),
      .HWRITE  (HWRITE),
      .HADDR   (HADDR),
      .HWDATA  (HWDATA),
      .HRDATA  (HRDATA),
      .SCLK    (SCLK),
      .MOSI    (MOSI),
      .CS_N    (CS_N),
      .IRQ     (IRQ)
   );

   // 100 MHz-style free-running clock
   initial HCLK = 1'b0;
   always #5 HCLK = ~HCLK;

   // Hard stop in case some sequence wedges despite its own bounds
   initial begin
      #500000;
      $display("[TB] FAIL watchdog: actual timeout, required completion");
      $fatal(1, "[TB] watchdog expired");
   end

   // Compare one observed value against its hand-computed expectation
   task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
      numVectors++;
      if (actual !== expected) begin
         numMiscompares++;
         $display("[TB] FAIL %s: actual 0x%0h, required 0x%0h", name, actual, expected);
      end
   endtask

   // Single AHB write: address phase then data phase, returns before the commit edge
   task automatic busWrite(input logic [3:0] addr, input logic [31:0] data);
      @(negedge HCLK);
      HSEL   = 1'b1;
      HTRANS = 2'b10;
      HWRITE = 1'b1;
      HADDR  = addr;
      @(negedge HCLK);
      HSEL   = 1'b0;
      HTRANS = 2'b00;
      HWRITE = 1'b0;
      HWDATA = data;
   endtask

   // Single AHB read sampled during the data phase
   task automatic busRead(input logic [3:0] addr, output logic [31:0] data);
      @(negedge HCLK);
      HSEL   = 1'b1;
      HTRANS = 2'b10;
      HWRITE = 1'b0;
      HADDR  = addr;
      @(negedge HCLK);
      HSEL   = 1'b0;
      HTRANS = 2'b00;
      data   = HRDATA;
   endtask

   task automatic applyStimulus(input vec_t v);
      logic [31:0] rd;
      if (v.isWrite) begin
         busWrite(v.addr, v.data);
      end else begin
         busRead(v.addr, rd);
         checkOutput(v.name, rd, v.expected);
      end
   endtask

   task automatic doReset();
      @(negedge HCLK);
      HRESETn = 1'b0;
      repeat (2) @(negedge HCLK);
      HRESETn = 1'b1;
   endtask

   // Follow one frame from CS_N low to the next CS_N fall (or 20 idle cycles)
   task automatic captureFrame(input int half, output int lowCycles, output int rises,
                               output logic [31:0] bits, output int badRuns, output int gapCycles);
      int waitCnt;
      int run;
      logic prevSclk;
      logic started;
      waitCnt = 0;
      lowCycles = 0;
      rises = 0;
      bits = '0;
      badRuns = 0;
      gapCycles = 0;
      run = 0;
      started = 1'b0;
      while (CS_N !== 1'b0 && waitCnt < 300) begin
         @(negedge HCLK);
         waitCnt++;
      end
      prevSclk = SCLK;
      while (CS_N === 1'b0 && lowCycles < 2000) begin
         lowCycles++;
         if (SCLK !== prevSclk) begin
            if (started && run != half) badRuns++;
            started = 1'b1;
            run = 1;
            if (SCLK === 1'b1) begin
               rises++;
               bits = {bits[30:0], MOSI};
            end
         end else begin
            run++;
         end
         prevSclk = SCLK;
         @(negedge HCLK);
      end
      while (CS_N === 1'b1 && gapCycles < 20) begin
         gapCycles++;
         @(negedge HCLK);
      end
   endtask

   initial begin
      logic [31:0] rd;
      logic [31:0] bits;
      int lowCycles, rises, badRuns, gapCycles, cnt, k, sclkHigh, csLow;
      logic prev;

      HRESETn = 1'b0;
      HSEL    = 1'b0;
      HTRANS  = 2'b00;
      HWRITE  = 1'b0;
      HADDR   = 4'h0;
      HWDATA  = 32'h0;
      repeat (3) @(negedge HCLK);
      HRESETn = 1'b1;
      @(negedge HCLK);
      checkOutput("rstOutputs", {28'h0, IRQ, SCLK, MOSI, CS_N}, 32'h1);

      // Register-access vector table
      vecs.push_back('{1'b0, ADDR_ST,   32'h0,          32'h0000_0004, "rstStatus"});
      vecs.push_back('{1'b0, ADDR_CTRL, 32'h0,          32'h0000_3101, "rstCtrl"});
      vecs.push_back('{1'b0, ADDR_TX,   32'h0,          32'h0000_0000, "txdataReadsZero"});
      vecs.push_back('{1'b1, ADDR_CTRL, 32'h0000_0500,  32'h0,         "ctrlDisable"});
      vecs.push_back('{1'b0, ADDR_CTRL, 32'h0,          32'h0000_0500, "ctrlDiv5"});
      for (int i = 0; i < 9; i++) begin
         vecs.push_back('{1'b1, ADDR_TX, 32'h1000 + i, 32'h0, "txFill"});
      end
      vecs.push_back('{1'b0, ADDR_ST,   32'h0,          32'h0000_080A, "fullOvf"});
      vecs.push_back('{1'b1, ADDR_ST,   32'h0000_0008,  32'h0,         "ovfClearWr"});
      vecs.push_back('{1'b0, ADDR_ST,   32'h0,          32'h0000_0802, "ovfCleared"});
      vecs.push_back('{1'b1, ADDR_RSVD, 32'hFFFF_FFFF,  32'h0,         "rsvdWr"});
      vecs.push_back('{1'b0, ADDR_RSVD, 32'h0,          32'h0000_0000, "rsvdZero"});
      vecs.push_back('{1'b0, ADDR_CTRL, 32'h0,          32'h0000_0500, "ctrlAfterRsvd"});
      vecs.push_back('{1'b1, ADDR_CTRL, 32'h0000_0002,  32'h0,         "ctrlIrqWr"});
      vecs.push_back('{1'b0, ADDR_CTRL, 32'h0,          CTRL_IRQ_READ, "ctrlIrqEn"});
      vecs.push_back('{1'b1, ADDR_ST,   32'hFFFF_FFFF,  32'h0,         "statusWrAll"});
      vecs.push_back('{1'b0, ADDR_ST,   32'h0,          32'h0000_0802, "statusReadOnly"});
      for (int i = 0; i < vecs.size(); i++) begin
         applyStimulus(vecs[i]);
      end

      // Reset flushes the full FIFO and restores CTRL
      doReset();
      busRead(ADDR_ST, rd);
      checkOutput("flushStatus", rd, 32'h0000_0004);

      // Single frame at DIV=0
      busWrite(ADDR_CTRL, 32'h0000_0001);
      busWrite(ADDR_TX, 32'h0000_A5C3);
      @(negedge HCLK);
      checkOutput("csBeforeLoad", {31'h0, CS_N}, 32'h1);
      @(negedge HCLK);
      checkOutput("csFall", {31'h0, CS_N}, 32'h0);
      checkOutput("firstMosi", {31'h0, MOSI}, 32'h1);
      captureFrame(1, lowCycles, rises, bits, badRuns, gapCycles);
      checkOutput("a5c3Low", lowCycles, 33);
      checkOutput("a5c3Rises", rises, 16);
      checkOutput("a5c3Bits", bits, 32'h0000_A5C3);
      checkOutput("a5c3Halves", badRuns, 0);
      checkOutput("a5c3NoMore", gapCycles, 20);
      busRead(ADDR_ST, rd);
      checkOutput("a5c3Status", rd, 32'h0000_0004);

      // Two queued words at DIV=0 run back to back with one gap cycle
      busWrite(ADDR_CTRL, 32'h0000_0000);
      busWrite(ADDR_TX, 32'h0000_0001);
      busWrite(ADDR_TX, 32'h0000_8000);
      busWrite(ADDR_CTRL, 32'h0000_0001);
      captureFrame(1, lowCycles, rises, bits, badRuns, gapCycles);
      checkOutput("pairLow1", lowCycles, 33);
      checkOutput("pairBits1", bits, 32'h0000_0001);
      checkOutput("pairGap", gapCycles, 1);
      captureFrame(1, lowCycles, rises, bits, badRuns, gapCycles);
      checkOutput("pairLow2", lowCycles, 33);
      checkOutput("pairBits2", bits, 32'h0000_8000);
      checkOutput("pairEnd", gapCycles, 20);

      // DIV=3: four-cycle half periods and a four-cycle gap between frames
      busWrite(ADDR_CTRL, 32'h0000_0300);
      busWrite(ADDR_TX, 32'h0000_1234);
      busWrite(ADDR_TX, 32'h0000_C0DE);
      busWrite(ADDR_CTRL, 32'h0000_0301);
      captureFrame(4, lowCycles, rises, bits, badRuns, gapCycles);
      checkOutput("div3Low1", lowCycles, 129);
      checkOutput("div3Bits1", bits, 32'h0000_1234);
      checkOutput("div3Halves", badRuns, 0);
      checkOutput("div3Gap", gapCycles, 4);
      captureFrame(4, lowCycles, rises, bits, badRuns, gapCycles);
      checkOutput("div3Low2", lowCycles, 129);
      checkOutput("div3Bits2", bits, 32'h0000_C0DE);

      // Asynchronous reset in the middle of a frame
      busWrite(ADDR_CTRL, 32'h0000_0001);
      busWrite(ADDR_TX, 32'h0000_FFFF);
      rises = 0;
      cnt = 0;
      prev = SCLK;
      while (rises < 7 && cnt < 300) begin
         @(negedge HCLK);
         cnt++;
         if (SCLK === 1'b1 && prev === 1'b0) rises++;
         prev = SCLK;
      end
      checkOutput("preRstOut", {29'h0, SCLK, MOSI, CS_N}, 32'h6);
      #2;
      HRESETn = 1'b0;
      #1;
      checkOutput("asyncRstOut", {29'h0, SCLK, MOSI, CS_N}, 32'h1);
      @(negedge HCLK);
      HRESETn = 1'b1;
      sclkHigh = 0;
      csLow = 0;
      for (int i = 0; i < 60; i++) begin
         @(negedge HCLK);
         if (SCLK !== 1'b0) sclkHigh++;
         if (CS_N !== 1'b1) csLow++;
      end
      checkOutput("postRstSclk", sclkHigh, 0);
      checkOutput("postRstCs", csLow, 0);
      busRead(ADDR_ST, rd);
      checkOutput("postRstStatus", rd, 32'h0000_0004);

`ifdef SPI_TX_IRQ_EN
      // TX-done interrupt timing and its two clearing paths
      busWrite(ADDR_CTRL, 32'h0000_0003);
      busWrite(ADDR_TX, 32'h0000_5A5A);
      cnt = 0;
      while (CS_N !== 1'b0 && cnt < 50) begin
         @(negedge HCLK);
         cnt++;
      end
      checkOutput("irqLowInFrame", {31'h0, IRQ}, 32'h0);
      cnt = 0;
      while (CS_N !== 1'b1 && cnt < 200) begin
         @(negedge HCLK);
         cnt++;
      end
      k = 0;
      while (IRQ !== 1'b1 && k < 20) begin
         @(negedge HCLK);
         k++;
      end
      checkOutput("irqDelay", k, 2);
      repeat (3) @(negedge HCLK);
      checkOutput("irqSticky", {31'h0, IRQ}, 32'h1);
      busWrite(ADDR_TX, 32'h0000_0000);
      @(negedge HCLK);
      checkOutput("irqClearTx", {31'h0, IRQ}, 32'h0);
      k = 0;
      while (IRQ !== 1'b1 && k < 200) begin
         @(negedge HCLK);
         k++;
      end
      checkOutput("irqRearm", {31'h0, IRQ}, 32'h1);
      busWrite(ADDR_CTRL, 32'h0000_0001);
      repeat (2) @(negedge HCLK);
      checkOutput("irqClearEn", {31'h0, IRQ}, 32'h0);
`else
      // Without the interrupt option IRQ never moves
      checkOutput("irqTied", {31'h0, IRQ}, 32'h0);
`endif

      $display("== %0d vectors applied, %0d miscompares ==", numVectors, numMiscompares);
      $finish;
   end

endmodule
